rect_multi: RTL and testbench

Parametrised successor to the single-rectangle overlay stage in the VGA pipeline. Draws up to N_RECT independently placed, sized and coloured rectangles over rgb_in, with fixed index priority and per-rectangle blink. Geometry is latched once per frame at vblank entry, so moving objects never tear. Sits between the background/track stage and the text/score overlay. Forwards all timing signals with a fixed latency.

---
 rtl/rect_multi.sv | 189 ++++++++++++++++++
 tb/tb_rect_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_multi.sv
// rect_multi: overlays up to N_RECT rectangles on the incoming pixel stream.
// Geometry, colours, enables and blink flags are shadowed once per frame at
// vblank entry, so an object never tears mid-frame. Every output trails its
// input by exactly two clocks: stage 1 does the per-rect hit test, stage 2
// resolves priority and applies blanking.
module rect_multi #(
    parameter int N_RECT       = 4,
    parameter int CNT_W        = 11,
    parameter int RGB_W        = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        hcount_in,
    input  logic [CNT_W-1:0]        vcount_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    hblnk_in,
    input  logic                    vblnk_in,
    input  logic [RGB_W-1:0]        rgb_in,
    input  logic [N_RECT*CNT_W-1:0] xpos_in,
    input  logic [N_RECT*CNT_W-1:0] ypos_in,
    input  logic [N_RECT*CNT_W-1:0] width_in,
    input  logic [N_RECT*CNT_W-1:0] height_in,
    input  logic [N_RECT*RGB_W-1:0] color_in,
    input  logic [N_RECT-1:0]       enable_in,
    input  logic [N_RECT-1:0]       blink_in,
    output logic [CNT_W-1:0]        hcount_out,
    output logic [CNT_W-1:0]        vcount_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    hblnk_out,
    output logic                    vblnk_out,
    output logic [RGB_W-1:0]        rgb_out,
    output logic [N_RECT-1:0]       hit_out
);

    // Frame counter is at least one bit wide so BLINK_FRAMES=1 still works
    // (phase then toggles on every frame edge).
    localparam int              FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic                    r_vblnk_prev;
    logic                    w_frame_edge;
    logic [N_RECT*CNT_W-1:0] r_xpos, r_ypos, r_width, r_height;
    logic [N_RECT*RGB_W-1:0] r_color;
    logic [N_RECT-1:0]       r_enable, r_blink;
    logic [FC_W-1:0]         r_fcnt;
    logic                    r_phase;

    logic [N_RECT-1:0]       w_hit;
    logic [RGB_W-1:0]        w_color [N_RECT];

    logic [N_RECT-1:0]       r_hit1;
    logic [CNT_W-1:0]        r_hcount1, r_vcount1;
    logic                    r_hsync1, r_vsync1, r_hblnk1, r_vblnk1;
    logic [RGB_W-1:0]        r_rgb1;
    logic                    w_blank1;
    logic [RGB_W-1:0]        w_pix;

    logic [N_RECT-1:0]       r_hit2;
    logic [CNT_W-1:0]        r_hcount2, r_vcount2;
    logic                    r_hsync2, r_vsync2, r_hblnk2, r_vblnk2;
    logic [RGB_W-1:0]        r_rgb2;

    // The previous-vblank register resets to 0, so vblank already high on the
    // first clock after reset is treated as a frame edge.
    assign w_frame_edge = vblnk_in & ~r_vblnk_prev;

    // Frame-edge detection, shadow latching and blink phase generation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vblnk_prev <= 1'b0;
            r_xpos       <= '0;
            r_ypos       <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_color      <= '0;
            r_enable     <= '0;
            r_blink      <= '0;
            r_fcnt       <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (w_frame_edge) begin
                r_xpos   <= xpos_in;
                r_ypos   <= ypos_in;
                r_width  <= width_in;
                r_height <= height_in;
                r_color  <= color_in;
                r_enable <= enable_in;
                r_blink  <= blink_in;
                if (r_fcnt == FC_LAST) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end

    // Per-rect hit test. End coordinates carry an extra bit so a rect that
    // runs past the counter limit is clipped instead of wrapping to 0.
    for (genvar gi = 0; gi < N_RECT; gi++) begin : g_rect
        logic [CNT_W-1:0] w_x, w_y, w_w, w_h;
        logic [CNT_W:0]   w_x_end, w_y_end;
        logic             w_in_x, w_in_y;

        assign w_x         = r_xpos[gi*CNT_W +: CNT_W];
        assign w_y         = r_ypos[gi*CNT_W +: CNT_W];
        assign w_w         = r_width[gi*CNT_W +: CNT_W];
        assign w_h         = r_height[gi*CNT_W +: CNT_W];
        assign w_x_end     = {1'b0, w_x} + {1'b0, w_w};
        assign w_y_end     = {1'b0, w_y} + {1'b0, w_h};
        assign w_in_x      = (hcount_in >= w_x) && ({1'b0, hcount_in} < w_x_end);
        assign w_in_y      = (vcount_in >= w_y) && ({1'b0, vcount_in} < w_y_end);
        assign w_hit[gi]   = r_enable[gi] & ~(r_blink[gi] & r_phase) & w_in_x & w_in_y;
        assign w_color[gi] = r_color[gi*RGB_W +: RGB_W];
    end

    // Stage 1: register hit vector together with the pixel and its timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit1    <= '0;
            r_hcount1 <= '0;
            r_vcount1 <= '0;
            r_hsync1  <= 1'b0;
            r_vsync1  <= 1'b0;
            r_hblnk1  <= 1'b0;
            r_vblnk1  <= 1'b0;
            r_rgb1    <= '0;
        end else begin
            r_hit1    <= w_hit;
            r_hcount1 <= hcount_in;
            r_vcount1 <= vcount_in;
            r_hsync1  <= hsync_in;
            r_vsync1  <= vsync_in;
            r_hblnk1  <= hblnk_in;
            r_vblnk1  <= vblnk_in;
            r_rgb1    <= rgb_in;
        end
    end

    // Priority select: scan from the highest index down so index 0 wins.
    always_comb begin
        w_pix = r_rgb1;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (r_hit1[i]) begin
                w_pix = w_color[i];
            end
        end
    end

    assign w_blank1 = r_hblnk1 | r_vblnk1;

    // Stage 2: register composed pixel, blanked hits and forwarded timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit2    <= '0;
            r_hcount2 <= '0;
            r_vcount2 <= '0;
            r_hsync2  <= 1'b0;
            r_vsync2  <= 1'b0;
            r_hblnk2  <= 1'b0;
            r_vblnk2  <= 1'b0;
            r_rgb2    <= '0;
        end else begin
            r_hit2    <= w_blank1 ? '0 : r_hit1;
            r_rgb2    <= w_blank1 ? '0 : w_pix;
            r_hcount2 <= r_hcount1;
            r_vcount2 <= r_vcount1;
            r_hsync2  <= r_hsync1;
            r_vsync2  <= r_vsync1;
            r_hblnk2  <= r_hblnk1;
            r_vblnk2  <= r_vblnk1;
        end
    end

    assign hcount_out = r_hcount2;
    assign vcount_out = r_vcount2;
    assign hsync_out  = r_hsync2;
    assign vsync_out  = r_vsync2;
    assign hblnk_out  = r_hblnk2;
    assign vblnk_out  = r_vblnk2;
    assign rgb_out    = r_rgb2;
    assign hit_out    = r_hit2;

endmodule

// File: tb/tb_rect_multi.sv
// Scoreboard bench for rect_multi: directed pixels with hand-computed
// expectations are queued at issue time; a monitor pops and compares them
// two clocks later.
module tb_rect_multi;

    localparam int N  = 4;
    localparam int CW = 11;
    localparam int RW = 12;
    localparam int BF = 2;
    localparam logic [RW-1:0] BG = 12'h5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [CW-1:0]     hcount_in, vcount_in;
    logic              hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [RW-1:0]     rgb_in;
    logic [N*CW-1:0]   xpos_in, ypos_in, width_in, height_in;
    logic [N*RW-1:0]   color_in;
    logic [N-1:0]      enable_in, blink_in;
    logic [CW-1:0]     hcount_out, vcount_out;
    logic              hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [RW-1:0]     rgb_out;
    logic [N-1:0]      hit_out;

    rect_multi #(.N_RECT(N), .CNT_W(CW), .RGB_W(RW), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .xpos_in(xpos_in), .ypos_in(ypos_in),
        .width_in(width_in), .height_in(height_in),
        .color_in(color_in), .enable_in(enable_in), .blink_in(blink_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .hit_out(hit_out)
    );

    typedef struct {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          hs;
        logic          vs;
        logic          hb;
        logic [RW-1:0] rgb;
        logic [N-1:0]  hit;
        string         tag;
    } exp_t;

    exp_t sb[$];
    logic chk_in = 1'b0;
    logic chk_d1 = 1'b0;
    logic chk_d2 = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Bench-side two-stage tag pipe marking which output cycles carry a
    // queued pixel.
    always @(posedge clk) begin
        chk_d1 <= chk_in;
        chk_d2 <= chk_d1;
    end

    // Monitor: pop one expectation whenever a tagged pixel reaches the output.
    always @(negedge clk) begin
        exp_t e;
        if (chk_d2) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: output pixel with no expectation queued");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (rgb_out !== e.rgb) begin
                    n_fail++;
                    $display("FAIL %s rgb: got %h want %h", e.tag, rgb_out, e.rgb);
                end
                n_checks++;
                if (hit_out !== e.hit) begin
                    n_fail++;
                    $display("FAIL %s hit: got %b want %b", e.tag, hit_out, e.hit);
                end
                n_checks++;
                if (hcount_out !== e.h || vcount_out !== e.v || hsync_out !== e.hs ||
                    vsync_out !== e.vs || hblnk_out !== e.hb || vblnk_out !== 1'b0) begin
                    n_failures_timing(e);
                end
                $display("pix %s (%0d,%0d) rgb=%h hit=%b", e.tag, e.h, e.v, rgb_out, hit_out);
            end
        end
    end

    task automatic n_failures_timing(input exp_t e);
        n_fail++;
        $display("FAIL %s timing: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b want h=%0d v=%0d hs=%b vs=%b hb=%b vb=0",
                 e.tag, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                 e.h, e.v, e.hs, e.vs, e.hb);
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h,
                            input logic [RW-1:0] c);
        xpos_in[i*CW +: CW]   = CW'(x);
        ypos_in[i*CW +: CW]   = CW'(y);
        width_in[i*CW +: CW]  = CW'(w);
        height_in[i*CW +: CW] = CW'(h);
        color_in[i*RW +: RW]  = c;
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic hb,
                       input logic [RW-1:0] exp_rgb, input logic [N-1:0] exp_hit);
        exp_t e;
        @(negedge clk);
        hcount_in = CW'(h);
        vcount_in = CW'(v);
        hsync_in  = ^hcount_in;
        vsync_in  = ^vcount_in;
        hblnk_in  = hb;
        vblnk_in  = 1'b0;
        rgb_in    = BG;
        chk_in    = 1'b1;
        e.h   = CW'(h);
        e.v   = CW'(v);
        e.hs  = ^e.h;
        e.vs  = ^e.v;
        e.hb  = hb;
        e.rgb = exp_rgb;
        e.hit = exp_hit;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        chk_in   = 1'b0;
        hblnk_in = 1'b1;
        vblnk_in = 1'b0;
    endtask

    // One clean rising edge of vblank, held for two clocks.
    task automatic frame_edge();
        @(negedge clk);
        chk_in   = 1'b0;
        hblnk_in = 1'b1;
        vblnk_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vblnk_in = 1'b0;
    endtask

    // Blink visibility of rect0 for the six frames following edges 4..9.
    logic [5:0] vis_tbl = 6'b110011;

    initial begin
        rst = 1'b0;
        // Reset with random inputs: every output must stay at 0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hcount_in = CW'($urandom);  vcount_in = CW'($urandom);
            hsync_in  = 1'($urandom);   vsync_in  = 1'($urandom);
            hblnk_in  = 1'($urandom);   vblnk_in  = 1'($urandom);
            rgb_in    = RW'($urandom);
            xpos_in   = {$urandom, $urandom}; ypos_in   = {$urandom, $urandom};
            width_in  = {$urandom, $urandom}; height_in = {$urandom, $urandom};
            color_in  = {$urandom, $urandom};
            enable_in = N'($urandom);   blink_in  = N'($urandom);
            #2;
            n_checks++;
            if (hcount_out !== '0 || vcount_out !== '0 || hsync_out !== 1'b0 || vsync_out !== 1'b0 ||
                hblnk_out !== 1'b0 || vblnk_out !== 1'b0 || rgb_out !== '0 || hit_out !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h hit=%b want all 0",
                         hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, hit_out);
            end
            $display("reset cycle %0d rgb=%h hit=%b", k, rgb_out, hit_out);
        end

        // Release reset with vblank already high: first clock is frame edge 1.
        @(negedge clk);
        xpos_in = '0; ypos_in = '0; width_in = '0; height_in = '0; color_in = '0;
        set_rect(0, 100, 50, 10, 13, 12'hDF0);
        enable_in = 4'b0001;
        blink_in  = 4'b0000;
        chk_in    = 1'b0;
        hblnk_in  = 1'b1;
        vblnk_in  = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vblnk_in  = 1'b0;

        // Frame after edge 1: single rectangle and its borders.
        pix("single_tl",   100, 50, 1'b0, 12'hDF0, 4'b0001);
        pix("single_br",   109, 62, 1'b0, 12'hDF0, 4'b0001);
        pix("single_x99",   99, 50, 1'b0, BG,      4'b0000);
        pix("single_x110", 110, 50, 1'b0, BG,      4'b0000);
        pix("single_y63",  105, 63, 1'b0, BG,      4'b0000);
        pix("single_y49",  105, 49, 1'b0, BG,      4'b0000);
        pix("single_hblk", 104, 56, 1'b1, 12'h000, 4'b0000);

        // Mid-frame bus move must not take effect yet.
        set_rect(0, 200, 50, 10, 13, 12'hDF0);
        pix("latch_old",   105, 55, 1'b0, 12'hDF0, 4'b0001);
        pix("latch_new_no",205, 55, 1'b0, BG,      4'b0000);
        frame_edge();  // edge 2
        pix("latch_new",   205, 55, 1'b0, 12'hDF0, 4'b0001);
        pix("latch_old_no",105, 55, 1'b0, BG,      4'b0000);

        // Priority, zero-width and right-edge clipping scene.
        set_rect(0,  100, 50, 20, 20, 12'hF00);
        set_rect(1,  110, 60, 20, 20, 12'h0F0);
        set_rect(2, 2040,  0, 20, 10, 12'h00F);
        set_rect(3,    0,  0,  0, 10, 12'hFFF);
        enable_in = 4'b1111;
        pix("pre_edge3",   205, 55, 1'b0, 12'hDF0, 4'b0001);
        frame_edge();  // edge 3
        pix("prio_both",   115, 65, 1'b0, 12'hF00, 4'b0011);
        pix("prio_r1",     125, 75, 1'b0, 12'h0F0, 4'b0010);
        pix("prio_r0",     105, 55, 1'b0, 12'hF00, 4'b0001);
        pix("prio_hblk",   115, 65, 1'b1, 12'h000, 4'b0000);
        pix("clip_2040",  2040,  5, 1'b0, 12'h00F, 4'b0100);
        pix("clip_2047",  2047,  9, 1'b0, 12'h00F, 4'b0100);
        pix("clip_2039",  2039,  5, 1'b0, BG,      4'b0000);
        pix("clip_y10",   2047, 10, 1'b0, BG,      4'b0000);
        pix("nowrap_x0",     0,  5, 1'b0, BG,      4'b0000);
        pix("nowrap_x11",   11,  5, 1'b0, BG,      4'b0000);

        // Blink: rect0 blinks, rect1 does not.
        xpos_in = '0; ypos_in = '0; width_in = '0; height_in = '0; color_in = '0;
        set_rect(0, 100, 50, 10, 10, 12'hF00);
        set_rect(1, 300, 50, 10, 10, 12'h0F0);
        enable_in = 4'b0011;
        blink_in  = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            frame_edge();  // edges 4..9
            if (vis_tbl[k]) pix("blink_r0_on",  105, 55, 1'b0, 12'hF00, 4'b0001);
            else            pix("blink_r0_off", 105, 55, 1'b0, BG,      4'b0000);
            pix("blink_r1", 305, 55, 1'b0, 12'h0F0, 4'b0010);
        end

        repeat (4) idle();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
